mult_rs: RTL and testbench
==========================

Name: mult_rs

Overview:
- Reservation station feeding the pipelined multiply functional unit.
- Accepts renamed multiply ops from dispatch, holds them until both source operands are available, and issues at most one ready op per cycle as an fu_pkt_t.
- Snoops the CDB for operand wakeup.
- Transmit side of the fu_pkt_t interface whose receiver is the multiply FU; the FU accepts one packet every cycle, so there is no issue back-pressure.

Parameters:
- DEPTH, 4, number of station entries (2..16)
- ROB_TAG_W, 5, width of ROB tags; must match types::fu_pkt_t.rob_tag

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  synchronous squash of all entries
- dispatch_valid  in  1  dispatch offers an op
- dispatch_ready  out  1  station can accept an op this cycle
- dispatch_pkt  in  fu_pkt_t  op (muldiv_op, rob_tag, rvfi, rs1_v, rs2_v); rsN_v meaningful only if rsN_rdy
- rs1_rdy  in  1  rs1_v already valid
- rs1_src_tag  in  ROB_TAG_W  producer tag of rs1 when not ready
- rs2_rdy  in  1  rs2_v already valid
- rs2_src_tag  in  ROB_TAG_W  producer tag of rs2 when not ready
- cdb_in  in  cdb_t  broadcast result (valid, rob_tag, data)
- mult_pkt_out  out  fu_pkt_t  issued op to multiply FU; valid=0 when idle
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Storage organisation
  - Collapsing queue; index 0 is the oldest entry.
  - Each entry holds: valid, pkt, rdy1, tag1, rdy2, tag2.
- Reset
  - All entries invalid, occupancy=0.
  - mult_pkt_out all-zero (valid=0).
  - dispatch_ready=1.
- Dispatch accept
  - Handshake: dispatch_ready = (occupancy < DEPTH). It does not depend on a same-cycle issue.
  - Accept occurs when dispatch_valid && dispatch_ready.
  - The accepted op is written at index occupancy-issued, where issued = 1 if an issue occurs this cycle.
- Dispatch-cycle snoop
  - If an operand is not ready and cdb_in.valid && cdb_in.rob_tag == its src tag, the entry is written with that operand ready and data = cdb_in.data.
  - This applies to rs1 and rs2 independently, and to both when they share the same tag.
- Wakeup
  - Every cycle, each valid entry with rdyN=0 and tagN == cdb_in.rob_tag (cdb_in.valid=1) captures cdb_in.data into rsN_v and sets rdyN=1 at the clock edge.
- Select
  - Combinational from registered state only.
  - Picks the lowest-index valid entry with rdy1 && rdy2.
- Issue output
  - mult_pkt_out = that entry's pkt with valid=1; otherwise all-zero.
  - On the clock edge, the issued entry is removed and all higher entries shift down by one, carrying any same-cycle wakeup.
- Latency
  - An op dispatched with both operands ready, or completed by a dispatch-cycle snoop, appears on mult_pkt_out the cycle after acceptance.
  - An op woken by a CDB broadcast in cycle N issues no earlier than cycle N+1.
- Full / empty
  - Full (occupancy==DEPTH): dispatch_ready=0, even in a cycle where an issue occurs.
  - Empty: mult_pkt_out.valid=0.
- Simultaneous events
  - Dispatch, issue and wakeup may all occur in one cycle.
  - occupancy next = occupancy + accept − issued.
- Flush
  - All entries are invalidated at the edge; occupancy becomes 0.
  - A same-cycle dispatch is dropped.
  - mult_pkt_out is still driven from pre-flush state during the flush cycle; the FU discards it under the same flush.
- Reset mid-operation
  - Asynchronous assertion immediately clears entries and outputs, regardless of clk.
- Orientation: an issued entry never reissues; duplicate ROB tags in the station are not expected.

Optional Feature:
- Macro: MULT_RS_WAKEUP_BYPASS_EN
- Defined:
  - Select also considers entries whose only missing operand(s) match the current cdb_in.
  - The missing operand is forwarded from cdb_in.data into mult_pkt_out.
  - Wakeup-to-issue latency becomes 0 cycles. This creates a combinational cdb_in→mult_pkt_out path.
- Undefined:
  - Select uses registered readiness only.
  - Wakeup-to-issue latency is 1 cycle, per Behaviour.

Test Plan:
- Reset, then dispatch mul_op with rob_tag=3, rs1_v=6, rs2_v=7, both ready
  - → next cycle mult_pkt_out.valid=1, rob_tag=3, rs1_v=6, rs2_v=7.
  - Cycle after that, valid=0 and occupancy=0.
- Dispatch tag=5 with rs1 waiting on src tag 9 (rs2 ready=2); hold cdb idle 3 cycles, then drive cdb {valid=1, rob_tag=9, data=0x10}
  - → no issue while waiting.
  - Issues the next cycle with rs1_v=0x10 (same cycle if MULT_RS_WAKEUP_BYPASS_EN is defined).
- Dispatch an op whose rs1 src tag=4 while cdb_in carries tag 4 with data=0xAB in the same cycle
  - → entry captures 0xAB.
  - Issues the next cycle.
- DEPTH=4: dispatch 4 non-ready ops (tags 1–4)
  - → dispatch_ready=0 and occupancy=4.
  - Wake tag 3's operand → tag 3 issues, entries collapse, dispatch_ready returns to 1 the following cycle.
- Two entries become ready in the same cycle (tags 7 then 8 dispatched in that order)
  - → tag 7 issues first, tag 8 the next cycle.
- Fill 3 entries, assert flush together with dispatch_valid
  - → next cycle occupancy=0 and mult_pkt_out.valid=0.
  - The dispatched op is never issued.
  - Separately, assert rst low mid-stream → outputs clear without a clock edge.

Source files
------------

// File: rtl/mult_rs.sv
// mult_rs: multiply reservation station, collapsing queue with CDB wakeup.
// Optional MULT_RS_WAKEUP_BYPASS_EN lets a same-cycle CDB hit issue directly.
package types;
  localparam int PKT_TAG_W = 5;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } rvfi_t;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           muldiv_op;
    logic [PKT_TAG_W-1:0] rob_tag;
    rvfi_t                rvfi;
    logic [XLEN-1:0]      rs1_v;
    logic [XLEN-1:0]      rs2_v;
  } fu_pkt_t;

  typedef struct packed {
    logic                 valid;
    logic [PKT_TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]      data;
  } cdb_t;
endpackage

module mult_rs
  import types::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  fu_pkt_t                    dispatch_pkt,
  input  logic                       rs1_rdy,
  input  logic [ROB_TAG_W-1:0]       rs1_src_tag,
  input  logic                       rs2_rdy,
  input  logic [ROB_TAG_W-1:0]       rs2_src_tag,
  input  cdb_t                       cdb_in,
  output fu_pkt_t                    mult_pkt_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    fu_pkt_t              pkt;
    logic                 rdy1;
    logic [ROB_TAG_W-1:0] tag1;
    logic                 rdy2;
    logic [ROB_TAG_W-1:0] tag2;
  } ent_t;

  ent_t [DEPTH-1:0] ent;
  ent_t [DEPTH-1:0] woke;
  ent_t [DEPTH-1:0] nxt;
  ent_t             fresh;

  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic [DEPTH-1:0] ok1;
  logic [DEPTH-1:0] ok2;

  logic          issue;
  logic [CW-1:0] sel;
  logic          accept;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] occ_nxt;
  logic          snoop1;
  logic          snoop2;

  // The incoming valid bit is implied by the handshake.
  logic unused;
  assign unused = dispatch_pkt.valid;

  assign dispatch_ready = (occupancy < CW'(DEPTH));
  assign accept = dispatch_valid && dispatch_ready;

  // CDB tag match per entry and per operand; readiness for select.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    ok1 = '0;
    ok2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = cdb_in.valid && ent[i].valid && !ent[i].rdy1
             && (ent[i].tag1 == cdb_in.rob_tag);
      hit2[i] = cdb_in.valid && ent[i].valid && !ent[i].rdy2
             && (ent[i].tag2 == cdb_in.rob_tag);
`ifdef MULT_RS_WAKEUP_BYPASS_EN
      ok1[i] = ent[i].rdy1 || hit1[i];
      ok2[i] = ent[i].rdy2 || hit2[i];
`else
      ok1[i] = ent[i].rdy1;
      ok2[i] = ent[i].rdy2;
`endif
    end
  end

  // Oldest-first select; drives the FU packet directly.
  always_comb begin
    issue = 1'b0;
    sel = '0;
    mult_pkt_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!issue && ent[i].valid && ok1[i] && ok2[i]) begin
        issue = 1'b1;
        sel = CW'(i);
        mult_pkt_out = ent[i].pkt;
        mult_pkt_out.valid = 1'b1;
`ifdef MULT_RS_WAKEUP_BYPASS_EN
        if (hit1[i]) mult_pkt_out.rs1_v = cdb_in.data;
        if (hit2[i]) mult_pkt_out.rs2_v = cdb_in.data;
`endif
      end
    end
  end

  // New entry, with operands captured from a same-cycle broadcast.
  always_comb begin
    snoop1 = !rs1_rdy && cdb_in.valid
          && (cdb_in.rob_tag == rs1_src_tag);
    snoop2 = !rs2_rdy && cdb_in.valid
          && (cdb_in.rob_tag == rs2_src_tag);
    fresh = '0;
    fresh.valid = 1'b1;
    fresh.pkt = dispatch_pkt;
    fresh.pkt.valid = 1'b1;
    fresh.rdy1 = rs1_rdy || snoop1;
    fresh.tag1 = rs1_src_tag;
    fresh.rdy2 = rs2_rdy || snoop2;
    fresh.tag2 = rs2_src_tag;
    if (snoop1) fresh.pkt.rs1_v = cdb_in.data;
    if (snoop2) fresh.pkt.rs2_v = cdb_in.data;
  end

  // Wakeup, collapse above the issued slot, then append.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent[i];
      if (hit1[i]) begin
        woke[i].rdy1 = 1'b1;
        woke[i].pkt.rs1_v = cdb_in.data;
      end
      if (hit2[i]) begin
        woke[i].rdy2 = 1'b1;
        woke[i].pkt.rs2_v = cdb_in.data;
      end
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (issue && (CW'(i) >= sel)) nxt[i] = woke[i+1];
      else nxt[i] = woke[i];
    end
    nxt[DEPTH-1] = issue ? '0 : woke[DEPTH-1];
    wr_idx = occupancy - CW'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (CW'(i) == wr_idx)) nxt[i] = fresh;
    end
    occ_nxt = occupancy + CW'(accept) - CW'(issue);
  end

  // Station state; flush drops everything including a same-cycle dispatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent <= '0;
      occupancy <= '0;
    end else if (flush) begin
      ent <= '0;
      occupancy <= '0;
    end else begin
      ent <= nxt;
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_mult_rs.sv
// tb_mult_rs: directed stimulus with a queue scoreboard
// and a negedge monitor for mult_pkt_out.
module tb_mult_rs;
  import types::*;

`ifdef MULT_RS_WAKEUP_BYPASS_EN
  localparam int WL = 0;
`else
  localparam int WL = 1;
`endif

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] v1;
    logic [31:0] v2;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       dispatch_valid = 1'b0;
  logic       dispatch_ready;
  fu_pkt_t    dispatch_pkt = '0;
  logic       rs1_rdy = 1'b0;
  logic [4:0] rs1_src_tag = '0;
  logic       rs2_rdy = 1'b0;
  logic [4:0] rs2_src_tag = '0;
  cdb_t       cdb_in = '0;
  fu_pkt_t    mult_pkt_out;
  logic [2:0] occupancy;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mult_rs #(.DEPTH(4), .ROB_TAG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .dispatch_valid(dispatch_valid),
    .dispatch_ready(dispatch_ready),
    .dispatch_pkt(dispatch_pkt),
    .rs1_rdy(rs1_rdy),
    .rs1_src_tag(rs1_src_tag),
    .rs2_rdy(rs2_rdy),
    .rs2_src_tag(rs2_src_tag),
    .cdb_in(cdb_in),
    .mult_pkt_out(mult_pkt_out),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && mult_pkt_out.valid) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected actual tag=%0d cyc=%0d required none",
                 mult_pkt_out.rob_tag, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (mult_pkt_out.rob_tag !== e.tag || mult_pkt_out.rs1_v !== e.v1
            || mult_pkt_out.rs2_v !== e.v2 || cyc != e.cyc) begin
          failures++;
          $display("FAIL issue actual tag=%0d rs1=%0h rs2=%0h cyc=%0d required tag=%0d rs1=%0h rs2=%0h cyc=%0d",
                   mult_pkt_out.rob_tag, mult_pkt_out.rs1_v,
                   mult_pkt_out.rs2_v, cyc, e.tag, e.v1, e.v2, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] tag, input logic [31:0] v1,
                      input logic [31:0] v2, input int c);
    exp_t e;
    e.tag = tag;
    e.v1 = v1;
    e.v2 = v2;
    e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic disp(input logic [4:0] tag,
                      input logic r1, input logic [4:0] s1,
                      input logic [31:0] v1,
                      input logic r2, input logic [4:0] s2,
                      input logic [31:0] v2);
    dispatch_pkt = '0;
    dispatch_pkt.valid = 1'b1;
    dispatch_pkt.muldiv_op = 3'd1;
    dispatch_pkt.rob_tag = tag;
    dispatch_pkt.rvfi.pc = {27'd0, tag};
    dispatch_pkt.rs1_v = r1 ? v1 : 32'hDEAD_0001;
    dispatch_pkt.rs2_v = r2 ? v2 : 32'hDEAD_0002;
    rs1_rdy = r1;
    rs1_src_tag = s1;
    rs2_rdy = r2;
    rs2_src_tag = s2;
    dispatch_valid = 1'b1;
    step();
    dispatch_valid = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    cdb_in.valid = 1'b1;
    cdb_in.rob_tag = tag;
    cdb_in.data = data;
  endtask

  task automatic cdb_idle();
    cdb_in = '0;
  endtask

  initial begin
    step();
    step();
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ready", 32'(dispatch_ready), 1);
    chk("rst_out_zero", 32'(|mult_pkt_out), 0);
    rst = 1'b1;
    step();

    // both operands ready: issue next cycle
    push(5'd3, 32'd6, 32'd7, cyc + 1);
    disp(5'd3, 1'b1, 5'd0, 32'd6, 1'b1, 5'd0, 32'd7);
    step();
    chk("t1_occ", 32'(occupancy), 0);
    chk("t1_valid", 32'(mult_pkt_out.valid), 0);

    // wait on tag 9, then wake
    disp(5'd5, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0, 32'd2);
    for (int i = 0; i < 3; i++) step();
    chk("t2_wait_occ", 32'(occupancy), 1);
    chk("t2_wait_valid", 32'(mult_pkt_out.valid), 0);
    push(5'd5, 32'h10, 32'd2, cyc + WL);
    cdb(5'd9, 32'h10);
    step();
    cdb_idle();
    step();
    chk("t2_occ", 32'(occupancy), 0);

    // dispatch-cycle snoop
    push(5'd6, 32'hAB, 32'd3, cyc + 1);
    cdb(5'd4, 32'hAB);
    disp(5'd6, 1'b0, 5'd4, 32'd0, 1'b1, 5'd0, 32'd3);
    cdb_idle();
    step();
    chk("t3_occ", 32'(occupancy), 0);

    // fill, wake the third, collapse, drain
    for (int k = 1; k <= 4; k++)
      disp(5'(k), 1'b0, 5'(16 + k), 32'd0, 1'b1, 5'd0, 32'd1);
    chk("t4_full_occ", 32'(occupancy), 4);
    chk("t4_full_ready", 32'(dispatch_ready), 0);
    push(5'd3, 32'h33, 32'd1, cyc + WL);
    cdb(5'd19, 32'h33);
    step();
    cdb_idle();
    chk("t4_issue_occ", 32'(occupancy), WL ? 4 : 3);
    chk("t4_issue_ready", 32'(dispatch_ready), WL ? 0 : 1);
    step();
    chk("t4_after_occ", 32'(occupancy), 3);
    chk("t4_after_ready", 32'(dispatch_ready), 1);
    push(5'd1, 32'h41, 32'd1, cyc + WL);
    cdb(5'd17, 32'h41);
    step();
    push(5'd2, 32'h42, 32'd1, cyc + WL);
    cdb(5'd18, 32'h42);
    step();
    push(5'd4, 32'h44, 32'd1, cyc + WL);
    cdb(5'd20, 32'h44);
    step();
    cdb_idle();
    step();
    chk("t4_drain_occ", 32'(occupancy), 0);

    // two ready together: older first
    disp(5'd7, 1'b0, 5'd25, 32'd0, 1'b1, 5'd0, 32'd1);
    disp(5'd8, 1'b0, 5'd25, 32'd0, 1'b1, 5'd0, 32'd1);
    push(5'd7, 32'h55, 32'd1, cyc + WL);
    push(5'd8, 32'h55, 32'd1, cyc + WL + 1);
    cdb(5'd25, 32'h55);
    step();
    cdb_idle();
    step();
    step();
    chk("t5_occ", 32'(occupancy), 0);

    // flush with concurrent dispatch
    for (int k = 0; k < 3; k++)
      disp(5'(10 + k), 1'b0, 5'(26 + k), 32'd0, 1'b1, 5'd0, 32'd1);
    chk("t6_fill_occ", 32'(occupancy), 3);
    flush = 1'b1;
    disp(5'd13, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9);
    flush = 1'b0;
    chk("t6_occ", 32'(occupancy), 0);
    chk("t6_valid", 32'(mult_pkt_out.valid), 0);
    cdb(5'd26, 32'h66);
    step();
    cdb_idle();
    step();
    step();
    chk("t6_late_occ", 32'(occupancy), 0);

    // asynchronous reset mid-stream
    disp(5'd14, 1'b0, 5'd29, 32'd0, 1'b1, 5'd0, 32'd1);
    disp(5'd15, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd5);
    chk("t7_pre_valid", 32'(mult_pkt_out.valid), 1);
    chk("t7_pre_occ", 32'(occupancy), 2);
    #1 rst = 1'b0;
    #1;
    chk("t7_valid", 32'(mult_pkt_out.valid), 0);
    chk("t7_occ", 32'(occupancy), 0);
    chk("t7_ready", 32'(dispatch_ready), 1);
    step();
    rst = 1'b1;
    step();
    chk("t7_post_occ", 32'(occupancy), 0);

    step();
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
